// File: rtl/snn_ram_arbiter_pkg.sv
// Shared sizing helpers and defaults for the SNN RAM arbiter slice.
package snn_ram_arbiter_pkg;

    localparam int unsigned NUM_REQ_DEF = 2;
    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned ADDR_W_DEF  = 8;

    // Round-robin pointer width; never below one bit so NUM_REQ=2 still has a pointer.
    function automatic int unsigned arb_ptr_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/snn_ram_arbiter_if.sv
// Requester-side bus of the RAM arbiter: flattened per-requester request lanes plus returns.
interface snn_ram_arbiter_if
    import snn_ram_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
    parameter int unsigned DATA_WIDTH = DATA_W_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_W_DEF
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            lock;
    logic [NUM_REQ-1:0]            we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            rvalid;
    logic [DATA_WIDTH-1:0]         rdata;

    modport master (
        output req, lock, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, lock, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/snn_ram_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or after ptr, wrapping mod NUM_REQ.
module snn_ram_arbiter_rr_pick
    import snn_ram_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQ = NUM_REQ_DEF,
    localparam int unsigned PTR_W   = arb_ptr_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_c,
    output logic [PTR_W-1:0]   idx_c,
    output logic               any_c
);

    always_comb begin : search
        int unsigned j;
        gnt_c = '0;
        idx_c = '0;
        any_c = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            // Explicit wrap so non-power-of-two requester counts stay in range.
            j = 32'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!any_c && req[PTR_W'(j)]) begin
                any_c = 1'b1;
                idx_c = PTR_W'(j);
            end
        end
        if (any_c) gnt_c[idx_c] = 1'b1;
    end

endmodule

// File: rtl/snn_ram_arbiter.sv
// Shares one single-port synchronous RAM between NUM_REQ requesters: round-robin with burst lock.
module snn_ram_arbiter
    import snn_ram_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
    parameter int unsigned DATA_WIDTH = DATA_W_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    snn_ram_arbiter_if.slave      bus,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    localparam int unsigned PTR_W = arb_ptr_w(NUM_REQ);

    logic [PTR_W-1:0]      ptr_q;
    logic [PTR_W-1:0]      lock_own_q;
    logic                  lock_vld_q;
    logic [ADDR_WIDTH-1:0] last_addr_q;
    logic [NUM_REQ-1:0]    rvalid_q;

    logic [NUM_REQ-1:0]    pick_gnt;
    logic [PTR_W-1:0]      pick_idx;
    logic                  pick_any;
    logic                  locked;
    logic [NUM_REQ-1:0]    gnt_c;
    logic [PTR_W-1:0]      win_idx;
    logic                  win_any;
    logic [PTR_W-1:0]      ptr_nxt;

    snn_ram_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .gnt_c (pick_gnt),
        .idx_c (pick_idx),
        .any_c (pick_any)
    );

    // Lock owner overrides round-robin only while it keeps requesting; reset blocks all grants.
    assign locked = rst_n && lock_vld_q && bus.req[lock_own_q];

    always_comb begin
        win_idx = pick_idx;
        win_any = rst_n && pick_any;
        gnt_c   = rst_n ? pick_gnt : '0;
        if (locked) begin
            win_idx        = lock_own_q;
            win_any        = 1'b1;
            gnt_c          = '0;
            gnt_c[win_idx] = 1'b1;
        end
    end

    // Idle cycles hold the last address so the RAM output stays stable.
    always_comb begin
        mem_addr = last_addr_q;
        mem_data = '0;
        mem_we   = 1'b0;
        if (win_any) begin
            mem_addr = bus.addr[32'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_data = bus.wdata[32'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
            mem_we   = bus.we[win_idx];
        end
    end

    assign ptr_nxt = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            lock_own_q  <= '0;
            lock_vld_q  <= 1'b0;
            last_addr_q <= '0;
            rvalid_q    <= '0;
        end else begin
            rvalid_q <= '0;
            if (lock_vld_q && !bus.req[lock_own_q]) lock_vld_q <= 1'b0;
            if (win_any) begin
                last_addr_q <= mem_addr;
                if (bus.lock[win_idx]) begin
                    lock_own_q <= win_idx;
                    lock_vld_q <= 1'b1;
                end else begin
                    ptr_q      <= ptr_nxt;
                    lock_vld_q <= 1'b0;
                end
                if (!bus.we[win_idx]) rvalid_q <= gnt_c;
            end
        end
    end

    // A read in flight when reset hits is discarded rather than reported.
    assign bus.gnt    = gnt_c;
    assign bus.rvalid = rvalid_q & {NUM_REQ{rst_n}};
    assign bus.rdata  = mem_q;

endmodule

// File: tb/tb_snn_ram_arbiter.sv
// Bench for snn_ram_arbiter: three requesters, behavioural RAM, directed steps then random traffic.
module tb_snn_ram_arbiter;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_we;
    logic [7:0] mem_q;

    always #10 clk = ~clk;

    snn_ram_arbiter_if #(.NUM_REQ(3), .DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

    snn_ram_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .mem_q    (mem_q)
    );

    // Single-port synchronous RAM: registered address, 1-cycle write.
    logic [7:0] ram [256];
    logic [7:0] ram_addr_q;
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_data;
        ram_addr_q <= mem_addr;
    end
    assign mem_q = ram[ram_addr_q];

    // Reference model state
    int         m_ptr;
    int         m_lk;
    logic [7:0] m_last;
    logic [7:0] m_shadow [256];
    logic [2:0] m_rv;
    logic [7:0] m_rd;
    int         total;
    int         bad;

    function automatic logic bitof(input logic [2:0] v, input int i);
        return v[2'(i)];
    endfunction

    function automatic logic [7:0] lane(input logic [23:0] v, input int i);
        return 8'(v >> (i * 8));
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check combinational and registered outputs, advance model.
    task automatic step(input logic r, input logic [2:0] rq, input logic [2:0] lk,
                        input logic [2:0] wv, input logic [23:0] ad, input logic [23:0] wd);
        int         w;
        logic [7:0] a;
        logic [7:0] d;
        rst_n     = r;
        bus.req   = rq;
        bus.lock  = lk;
        bus.we    = wv;
        bus.addr  = ad;
        bus.wdata = wd;
        @(negedge clk);
        w = -1;
        if (r) begin
            if (m_lk >= 0 && bitof(rq, m_lk)) w = m_lk;
            else
                for (int k = 0; k < N; k++)
                    if (w < 0 && bitof(rq, (m_ptr + k) % N)) w = (m_ptr + k) % N;
        end
        a = (w >= 0) ? lane(ad, w) : m_last;
        d = (w >= 0) ? lane(wd, w) : 8'h00;
        chk("gnt", 8'(bus.gnt), (w >= 0) ? 8'(8'h01 << w) : 8'h00);
        chk("mem_we", 8'(mem_we), (w >= 0) ? 8'(bitof(wv, w)) : 8'h00);
        chk("mem_data", mem_data, d);
        if (r) chk("mem_addr", mem_addr, a);
        chk("rvalid", 8'(bus.rvalid), r ? 8'(m_rv) : 8'h00);
        if (r && m_rv != 3'b000) chk("rdata", bus.rdata, m_rd);
        if (!r) begin
            m_ptr  = 0;
            m_lk   = -1;
            m_last = 8'h00;
            m_rv   = 3'b000;
        end else begin
            if (m_lk >= 0 && !bitof(rq, m_lk)) m_lk = -1;
            m_rv = 3'b000;
            if (w >= 0) begin
                m_last = a;
                if (bitof(lk, w)) m_lk = w;
                else begin
                    m_ptr = (w + 1) % N;
                    m_lk  = -1;
                end
                if (bitof(wv, w)) m_shadow[a] = d;
                else begin
                    m_rv = 3'(3'b001 << w);
                    m_rd = m_shadow[a];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b1, 3'b000, 3'b000, 3'b000, 24'h0, 24'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]      = 8'h00;
            m_shadow[i] = 8'h00;
        end
        ram_addr_q = 8'h00;
        rst_n      = 1'b0;
        bus.req    = '0;
        bus.lock   = '0;
        bus.we     = '0;
        bus.addr   = '0;
        bus.wdata  = '0;
        total      = 0;
        bad        = 0;
        m_ptr      = 0;
        m_lk       = -1;
        m_last     = 8'h00;
        m_rv       = 3'b000;
        m_rd       = 8'h00;
        @(posedge clk);
        #1;

        // Reset with everyone trying to write 0x30: nothing may reach the RAM
        step(1'b0, 3'b111, 3'b000, 3'b111, 24'h303030, 24'hFFFFFF);
        step(1'b0, 3'b111, 3'b000, 3'b111, 24'h303030, 24'hFFFFFF);

        // Write 0xA5 @0x10 by req0, then req1 reads it back
        step(1'b1, 3'b001, 3'b000, 3'b001, 24'h000010, 24'h0000A5);
        step(1'b1, 3'b010, 3'b000, 3'b000, 24'h001000, 24'h0);
        idle();
        chk("rdata_a5", bus.rdata, 8'hA5);
        // 0x30 must be untouched by the reset-time write attempts
        step(1'b1, 3'b100, 3'b000, 3'b000, 24'h300000, 24'h0);
        idle();

        // All three reading continuously from a fresh pointer
        step(1'b0, 3'b000, 3'b000, 3'b000, 24'h0, 24'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 3'b111, 3'b000, 3'b000, 24'h301000, 24'h0);
        idle();

        // Burst lock by req1 while req0/req2 wait, then release
        step(1'b0, 3'b000, 3'b000, 3'b000, 24'h0, 24'h0);
        step(1'b1, 3'b010, 3'b010, 3'b000, 24'h001000, 24'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 3'b111, 3'b010, 3'b000, 24'h301000, 24'h0);
        step(1'b1, 3'b111, 3'b000, 3'b000, 24'h301000, 24'h0);
        step(1'b1, 3'b111, 3'b000, 3'b000, 24'h301000, 24'h0);
        idle();

        // Idle after a read of 0x20 keeps the address and RAM output stable
        step(1'b1, 3'b001, 3'b000, 3'b001, 24'h000020, 24'h00005C);
        step(1'b1, 3'b100, 3'b000, 3'b000, 24'h200000, 24'h0);
        for (int i = 0; i < 3; i++) idle();
        chk("idle_addr", mem_addr, 8'h20);
        chk("idle_q", bus.rdata, 8'h5C);

        // Reset right after a granted read discards it and restarts the pointer
        step(1'b1, 3'b010, 3'b000, 3'b000, 24'h002000, 24'h0);
        step(1'b0, 3'b111, 3'b000, 3'b000, 24'h202020, 24'h0);
        step(1'b1, 3'b111, 3'b000, 3'b000, 24'h202020, 24'h0);
        idle();

        // Random traffic with occasional locks and resets
        for (int i = 0; i < 400; i++) begin
            logic       r;
            logic [2:0] rq;
            logic [2:0] lk;
            logic [2:0] wv;
            logic [23:0] ad;
            r  = ($urandom % 40) != 0;
            rq = 3'($urandom);
            lk = (($urandom % 4) == 0) ? 3'($urandom) : 3'b000;
            wv = 3'($urandom);
            ad = {4'h0, 4'($urandom), 4'h0, 4'($urandom), 4'h0, 4'($urandom)};
            step(r, rq, lk, wv, ad, 24'($urandom));
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
